// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arbiter
// Purpose  : Round-robin sharing of one combinational adder among NUM_REQ
//            requesters, with a one-deep registered response stage.
// Revision : 1.0
// ============================================================================
module adder_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_src1_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_src2_i,
    output logic [DATA_WIDTH-1:0]         add_src1_o,
    output logic [DATA_WIDTH-1:0]         add_src2_o,
    input  logic [DATA_WIDTH-1:0]         add_sum_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [ID_WIDTH-1:0]           rsp_id_o,
    output logic [DATA_WIDTH-1:0]         rsp_sum_o
);

    logic [ID_WIDTH-1:0]   r_ptr;
    logic                  r_rsp_valid;
    logic [ID_WIDTH-1:0]   r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_sum;

    logic                  w_can_accept;
    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_win;
    logic                  w_grant;
    logic [ID_WIDTH-1:0]   w_ptr_next;

    assign w_can_accept = !r_rsp_valid || rsp_ready_i;

    // Two descending passes: the wrapped region (k < ptr) is scanned first so
    // that any hit in the k >= ptr region overrides it, giving the circular
    // order ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k] && (k < int'(r_ptr))) begin
                w_found = 1'b1;
                w_win   = ID_WIDTH'(k);
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k] && (k >= int'(r_ptr))) begin
                w_found = 1'b1;
                w_win   = ID_WIDTH'(k);
            end
        end
    end

    assign w_grant    = w_found && w_can_accept && !rst_i;
    assign w_ptr_next = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;

    always_comb begin
        req_ready_o = '0;
        add_src1_o  = '0;
        add_src2_o  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant && (int'(w_win) == k)) begin
                req_ready_o[k] = 1'b1;
                add_src1_o     = req_src1_i[k*DATA_WIDTH +: DATA_WIDTH];
                add_src2_o     = req_src2_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A grant also covers the drain-and-refill case, so the slot never bubbles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
        end else if (w_grant) begin
            r_ptr       <= w_ptr_next;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_win;
            r_rsp_sum   <= add_sum_i;
        end else if (r_rsp_valid && rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_id_o    = r_rsp_id;
    assign rsp_sum_o   = r_rsp_sum;

endmodule
`default_nettype wire

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one 32-bit combinational adder instance between NUM_REQ requesters, e.g. PC+4, branch-target and address-calc paths.
- Uses round-robin arbitration with a valid/ready handshake on both sides.
- Registers the selected sum with the winner's ID, giving a one-cycle-latency response stream.
- Sits between the requesting datapath units and the adder; drives the adder operands and samples its sum.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, operand/sum width; must match the shared adder.
- ID_WIDTH, 2, width of the requester ID; must be >= ceil(log2(NUM_REQ)).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high.
- req_src1_i  input  NUM_REQ*DATA_WIDTH  packed first operands; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_src2_i  input  NUM_REQ*DATA_WIDTH  packed second operands, same packing.
- add_src1_o  output  DATA_WIDTH  operand to the shared adder src1.
- add_src2_o  output  DATA_WIDTH  operand to the shared adder src2.
- add_sum_i  input  DATA_WIDTH  sum returned from the shared adder (combinational).
- rsp_valid_o  output  1  response register holds a result.
- rsp_ready_i  input  1  consumer accepts the response.
- rsp_id_o  output  ID_WIDTH  index of the requester that produced rsp_sum_o.
- rsp_sum_o  output  DATA_WIDTH  registered sum.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - rsp_valid_o=0, rsp_id_o=0, rsp_sum_o=0.
  - Round-robin pointer ptr=0.
  - req_ready_o=0 for the cycle in which rst_i is high.
  - Any in-flight response is discarded.
- can_accept = !rsp_valid_o || rsp_ready_i (output slot empty or draining this cycle).
- Arbitration (combinational, each cycle):
  - Winner w = first k with req_valid_i[k]=1, scanning ptr, ptr+1, ..., wrapping NUM_REQ-1 -> 0.
  - If no request, or can_accept=0: no winner.
- Grant:
  - req_ready_o[w]=1 only when a winner exists and can_accept=1; all other bits 0.
  - req_ready_o depends combinationally on req_valid_i and rsp_ready_i.
  - Requesters must not make req_valid_i depend on req_ready_o.
- Adder drive:
  - With a winner: add_src1_o/add_src2_o = operands of w.
  - Otherwise: both driven 0.
- Capture (clock edge where a grant occurs):
  - rsp_sum_o <= add_sum_i; rsp_id_o <= w; rsp_valid_o <= 1; ptr <= (w+1) mod NUM_REQ.
  - Latency is exactly 1 cycle from acceptance to rsp_valid_o.
  - Throughput is 1 result per cycle when rsp_ready_i stays high.
- Drain without grant (rsp_valid_o && rsp_ready_i and no winner): rsp_valid_o <= 0. rsp_sum_o and rsp_id_o hold their values.
- Stall (rsp_valid_o && !rsp_ready_i):
  - No grant.
  - rsp_valid_o, rsp_id_o and rsp_sum_o hold stable.
  - ptr holds.
- Simultaneous drain and grant in the same cycle: the new result replaces the old with no bubble, and rsp_valid_o stays 1.
- ptr changes only on a grant; idle cycles keep it.
- Arithmetic: sum is modulo 2^DATA_WIDTH; carry-out is not reported; overflow wraps silently.
- Fairness: a continuously asserting requester is granted within NUM_REQ grants.
- Requester k must hold valid and operands stable until req_ready_o[k]; the block does not latch unaccepted requests.

Test Plan:
1. Reset then idle: rst_i=1 for 2 cycles, no requests. Expect all outputs 0, add_src1_o=add_src2_o=0, and ptr stays 0 across 5 idle cycles.
2. Single request: req1 valid with src1=0x0000_0004, src2=0x0040_0000, rsp_ready_i=1. Expect req_ready_o=4'b0010 in cycle 0; in cycle 1 rsp_valid_o=1, rsp_id_o=1, rsp_sum_o=0x0040_0004.
3. Round-robin: all 4 requesters valid continuously, rsp_ready_i=1. Expect grant order 0,1,2,3,0,1 and rsp_id_o following one cycle later, with no bubbles.
4. Backpressure: response valid with rsp_ready_i=0 for 3 cycles while req2 is valid. Expect req_ready_o=0 and rsp_sum_o/rsp_id_o stable. On rsp_ready_i=1, req2 is granted the same cycle and its result appears the next cycle.
5. Wrap-around: src1=0xFFFF_FFFF, src2=0x0000_0002. Expect rsp_sum_o=0x0000_0001 with no error indication.
6. Reset mid-stream: assert rst_i while rsp_valid_o=1 and requests are pending. Expect rsp_valid_o=0 next cycle and ptr=0; the first post-reset grant goes to the lowest-index valid requester.
